// File: rtl/pipe_ifid_queue_pkg.sv
// Shared definitions for the IF/ID instruction queue and the fetch/decode
// stages around it.
//   INS_W   : instruction word width
//   NOP_INS : instruction word presented to decode when nothing is queued
package pipe_ifid_queue_pkg;

    localparam int INS_W = 32;
    localparam logic [INS_W-1:0] NOP_INS = 32'h0000_0000;

endpackage

// File: rtl/ifid_queue_ram.sv
// Storage array for the IF/ID instruction queue.
// DEPTH x W register array with one synchronous write port and one
// asynchronous read port.
// Ports:
//   clock : write clock, rising edge
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, combinational from raddr
module ifid_queue_ram #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    // Contents are deliberately not reset; only pointers and count are.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_ifid_queue.sv
// Instruction queue between fetch and decode. Buffers {pc4, ins} pairs so a
// decode stall does not immediately stall fetch, presents the oldest entry
// to decode, and discards everything on a taken branch/jump flush.
// Ports:
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   if_valid/if_pc4/if_ins : entry offered by fetch
//   if_ready          : queue not full (depends on registered state only)
//   id_ready          : decode consumes the head entry
//   id_valid/id_pc4/id_ins : head entry; zeros / NOP when empty
//   flush             : drop all queued and incoming entries
//   count             : number of valid entries, 0..DEPTH
module pipe_ifid_queue
    import pipe_ifid_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     if_valid,
    input  logic [AW-1:0]            if_pc4,
    input  logic [AW-1:0]            if_ins,
    output logic                     if_ready,
    input  logic                     id_ready,
    output logic                     id_valid,
    output logic [AW-1:0]            id_pc4,
    output logic [AW-1:0]            id_ins,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   cnt;
    logic            empty;
    logic            full;
    logic            push;
    logic            pop;
    logic [2*AW-1:0] head;

    // Empty/full come from the count so a full queue is never mistaken for
    // an empty one when the pointers coincide.
    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));

    assign push = if_valid & ~full  & ~flush;
    assign pop  = id_ready & ~empty & ~flush;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            // Pointer width equals log2(DEPTH), so the increment wraps
            // modulo DEPTH on its own.
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                cnt <= cnt + CW'(1);
            end else if (pop && !push) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    ifid_queue_ram #(
        .DEPTH (DEPTH),
        .W     (2 * AW)
    ) u_ram (
        .clock (clock),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({if_pc4, if_ins}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    assign if_ready = ~full;
    assign id_valid = ~empty;
    assign id_pc4   = empty ? '0 : head[2*AW-1:AW];
    assign id_ins   = empty ? AW'(NOP_INS) : head[AW-1:0];
    assign count    = cnt;

endmodule
